// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline sequencer: load-use bubbles, branch flush, MEM wait freeze/timeout, boot drain
// Control outputs are Mealy (state + inputs); mem_fault is a pure FAULT-state decode.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_ena,
  output logic             freeze,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int BW = $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic lu;
  logic hazard_en;
  logic lu_stall;

  assign lu = ex_is_load & (ex_rd != 5'd0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    wait_cnt_d = wait_cnt_q;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_ena   = 1'b1;
    freeze     = 1'b0;
    hazard_en  = 1'b0;
    lu_stall   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
        idex_ena   = 1'b0;
        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
          state_d    = ST_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          freeze     = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WW'(1);
        end else begin
          hazard_en = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // An ack in the timeout cycle still counts as completion.
        if (mem_ack) begin
          hazard_en  = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q < WW'(MEM_TIMEOUT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      default: begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
        idex_ena   = 1'b0;
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Branch wins over load-use: the ID instruction is on the wrong path.
    if (hazard_en) begin
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_ena   = 1'b0;
      end else if (lu) begin
        pc_hold   = 1'b1;
        ifid_hold = 1'b1;
        idex_ena  = 1'b0;
        lu_stall  = 1'b1;
      end
    end

    stall_d = stall_q;
    if ((freeze || lu_stall) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign mem_fault    = (state_q == ST_FAULT);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken, mem_req, mem_ack;
    logic             pc_hold, ifid_hold, ifid_flush, idex_ena, freeze, mem_fault;
    logic [CNT_W-1:0] stall_cycles;
    logic [4:0]       ctl;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] NEUT  = 5'b00010;
    localparam logic [4:0] BOOTV = 5'b10100;
    localparam logic [4:0] FLTV  = 5'b10100;
    localparam logic [4:0] BR    = 5'b00100;
    localparam logic [4:0] LU    = 5'b11000;
    localparam logic [4:0] FRZ   = 5'b00011;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .BOOT_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_ena(idex_ena),
        .freeze(freeze), .mem_fault(mem_fault), .stall_cycles(stall_cycles)
    );

    assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_ena, freeze};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ctl", ctl, BOOTV);
        chk("reset_fault", mem_fault, 1'b0);
        chk("reset_stall", stall_cycles, 4'd0);

        @(negedge clk); rst = 1'b0; #1;
        chk("boot_c0", ctl, BOOTV);
        @(negedge clk); #1;
        chk("boot_c1", ctl, BOOTV);
        @(negedge clk); #1;
        chk("boot_run", ctl, NEUT);
        chk("boot_stall", stall_cycles, 4'd0);

        @(negedge clk); ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; #1;
        chk("lu_rs2", ctl, LU);
        @(negedge clk); ex_is_load = 0; ex_rd = 0; #1;
        chk("lu_after", ctl, NEUT);
        chk("lu_stall1", stall_cycles, 4'd1);
        @(negedge clk); ex_is_load = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1; #1;
        chk("lu_x0", ctl, NEUT);
        @(negedge clk); clr(); ex_is_load = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; #1;
        chk("lu_unused", ctl, NEUT);
        chk("lu_stall_x0", stall_cycles, 4'd1);
        @(negedge clk); id_use_rs1 = 1; #1;
        chk("lu_rs1", ctl, LU);

        @(negedge clk); ex_branch_taken = 1; #1;
        chk("br_vs_lu", ctl, BR);
        chk("br_stall_pre", stall_cycles, 4'd2);
        @(negedge clk); clr(); #1;
        chk("br_stall_post", stall_cycles, 4'd2);
        chk("br_after", ctl, NEUT);

        @(negedge clk); mem_req = 1; mem_ack = 1; #1;
        chk("mem_imm_ack", ctl, NEUT);

        @(negedge clk); mem_ack = 0; ex_branch_taken = 1; #1;
        chk("mw_c0", ctl, FRZ);
        @(negedge clk); #1;
        chk("mw_c1", ctl, FRZ);
        @(negedge clk); #1;
        chk("mw_c2", ctl, FRZ);
        @(negedge clk); mem_ack = 1; #1;
        chk("mw_ack_br", ctl, BR);
        @(negedge clk); clr(); #1;
        chk("mw_after", ctl, NEUT);
        chk("mw_stall", stall_cycles, 4'd5);

        @(negedge clk); mem_req = 1; mem_ack = 0; #1;
        chk("to_c0", ctl, FRZ);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk); #1;
            chk("to_frz", ctl, FRZ);
            chk("to_nofault", mem_fault, 1'b0);
        end
        @(negedge clk); mem_req = 0; #1;
        chk("to_fault_ctl", ctl, FLTV);
        chk("to_fault", mem_fault, 1'b1);
        chk("to_stall", stall_cycles, 4'd10);
        @(negedge clk); #1;
        chk("to_run", ctl, NEUT);
        chk("to_fault_clr", mem_fault, 1'b0);

        @(negedge clk); mem_req = 1; mem_ack = 0; #1;
        chk("ta_c0", ctl, FRZ);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk); #1;
            chk("ta_frz", ctl, FRZ);
        end
        @(negedge clk); mem_ack = 1; #1;
        chk("ta_ack", ctl, NEUT);
        @(negedge clk); clr(); #1;
        chk("ta_nofault", mem_fault, 1'b0);
        chk("ta_stall", stall_cycles, 4'd14);

        @(negedge clk); mem_req = 1; mem_ack = 0;
        repeat (4) @(negedge clk);
        @(negedge clk); mem_req = 0; #1;
        chk("sat_fault", mem_fault, 1'b1);
        chk("sat_stall", stall_cycles, 4'd15);
        @(negedge clk); ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; #1;
        chk("sat_lu", ctl, LU);
        @(negedge clk); clr(); #1;
        chk("sat_hold", stall_cycles, 4'd15);

        @(negedge clk); mem_req = 1; mem_ack = 0; #1;
        chk("ar_c0", ctl, FRZ);
        @(negedge clk); #1;
        chk("ar_c1", ctl, FRZ);
        #2 rst = 1'b1; #1;
        chk("ar_ctl", ctl, BOOTV);
        chk("ar_stall", stall_cycles, 4'd0);
        chk("ar_fault", mem_fault, 1'b0);
        @(negedge clk); clr();
        @(negedge clk); rst = 1'b0; #1;
        chk("ar_boot0", ctl, BOOTV);
        @(negedge clk); #1;
        chk("ar_boot1", ctl, BOOTV);
        chk("ar_fault2", mem_fault, 1'b0);
        @(negedge clk); #1;
        chk("ar_run", ctl, NEUT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
